// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg
//   Shared definitions for the FIFO drain-side serial transmitter:
//   FSM state encoding, FIFO command encodings and a counter-width helper.
//   Used by fifo_serial_tx and fifo_tx_baud_counter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  // Width of a counter that holds 0..max-1; never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/fifo_tx_baud_counter.sv
// fifo_tx_baud_counter
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; bit_tick_o is
//   high during the last count of every bit period.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   clr_i       restart the period so the next cycle is count 0
//   bit_tick_o  one-cycle pulse on the final cycle of a bit period
module fifo_tx_baud_counter
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Pops words from the FIFO read port (mode/empty handshake), latches each
//   word and sends it LSB-first as a start / data / [parity] / stop frame.
//   Optional feature macro: FIFO_TX_PARITY_EN inserts an even-parity bit
//   between the last data bit and the stop bit.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   fifo_empty    FIFO empty flag, sampled only in IDLE
//   fifo_dataout  FIFO read data, valid the cycle after a read command
//   fifo_mode     FIFO command: 00 idle, 10 read (one cycle per frame)
//   tx_enable     allows new frames to start, sampled only in IDLE
//   tx            serial line, idles high
//   busy          high from POP through STOP
//   done          one-cycle pulse in the first IDLE cycle after STOP
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout,
  output logic [1:0]        fifo_mode,
  input  logic              tx_enable,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              done_q, done_d;
  logic              bit_tick;

  // The period restarts as the FSM enters START so START lasts a full bit.
  fifo_tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (state_q == ST_LATCH),
    .bit_tick_o(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // Shift register holds payload only; it is reloaded before every use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

`ifdef FIFO_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (state_q == ST_LATCH) parity_q <= ^fifo_dataout;
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (tx_enable && !fifo_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LATCH;
      ST_LATCH: state_d = ST_START;
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_tick && (bit_cnt_q == LAST_BIT)) begin
`ifdef FIFO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: load on LATCH, shift after each data bit period
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = (state_q == ST_STOP) && bit_tick;
    if (state_q == ST_LATCH) begin
      shreg_d   = fifo_dataout;
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && bit_tick) begin
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    fifo_mode = MODE_IDLE;
    tx        = 1'b1;
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    unique case (state_q)
      ST_POP:    fifo_mode = MODE_READ;
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg_q[0];
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: tx = parity_q;
`endif
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

  localparam int DATA_W = 4;
  localparam int C      = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = 3 + (DATA_W + 2 + P) * C;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dataout;
  logic [1:0]        fifo_mode;
  logic              tx_enable;
  logic              tx;
  logic              busy;
  logic              done;

  fifo_serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dataout(fifo_dataout),
    .fifo_mode   (fifo_mode),
    .tx_enable   (tx_enable),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural FIFO driving the DUT, plus the list of words expected on the line
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                n_reads  = 0;
  int                n_starts = 0;

  // Reference model: a frame is an offset k counted from the qualifying cycle
  bit                m_active = 1'b0;
  bit                m_done   = 1'b0;
  int                m_k      = 0;
  logic [DATA_W-1:0] m_word   = '0;

  function automatic logic exp_tx(input int k, input logic [DATA_W-1:0] w);
    int b;
    if (k < 3) return 1'b1;
    b = (k - 3) / C;
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return w[b-1];
    if ((P == 1) && (b == DATA_W + 1)) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit s_pop, s_rst, s_en, s_empty;
    s_pop   = (fifo_mode == 2'b10);
    s_rst   = rst;
    s_en    = tx_enable;
    s_empty = fifo_empty;
    if (s_rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (m_k == FRAME - 1) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_k      = 0;
      end else begin
        m_k++;
      end
    end else begin
      m_done = 1'b0;
      if (s_en && !s_empty && exp_q.size() > 0) begin
        m_active = 1'b1;
        m_k      = 1;
        m_word   = exp_q.pop_front();
        n_starts++;
      end
    end
    #1;
    if (s_pop) begin
      n_reads++;
      chk("rd_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) fifo_dataout = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (m_active) begin
      chk("busy", {31'd0, busy}, 32'd1);
      chk("mode", {30'd0, fifo_mode}, (m_k == 1) ? 32'd2 : 32'd0);
      chk("tx",   {31'd0, tx}, {31'd0, exp_tx(m_k, m_word)});
      chk("done", {31'd0, done}, 32'd0);
    end else begin
      chk("busy", {31'd0, busy}, 32'd0);
      chk("mode", {30'd0, fifo_mode}, 32'd0);
      chk("tx",   {31'd0, tx}, 32'd1);
      chk("done", {31'd0, done}, {31'd0, m_done});
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      cyc(1);
      if (!m_active && fifo_q.size() == 0) break;
    end
    if (i == max) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    int i;
    rst          = 1'b1;
    tx_enable    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_dataout = '0;

    // Reset held for three cycles
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Single word 1010
    push(4'b1010);
    tx_enable = 1'b1;
    wait_idle(200);
    cyc(3);
    chk("reads_single", n_reads, 32'd1);

    // Empty FIFO with transmit enabled
    cyc(50);
    chk("reads_empty", n_reads, 32'd1);

    // Burst of four words loaded while disabled
    tx_enable = 1'b0;
    base = n_reads;
    push(4'b1000);
    push(4'b1110);
    push(4'b0010);
    push(4'b1011);
    cyc(5);
    tx_enable = 1'b1;
    wait_idle(500);
    cyc(3);
    chk("reads_burst", n_reads - base, 32'd4);

    // Parity-sensitive words
    push(4'b0111);
    push(4'b1111);
    wait_idle(300);
    cyc(3);

    // Reset during data bit 2
    push(4'b0110);
    for (i = 0; i < 200; i++) begin
      cyc(1);
      if (m_active && m_k == 3 + 3 * C) break;
    end
    if (i == 200) chk("timeout_mid", 32'd0, 32'd1);
    rst = 1'b1;
    base = n_reads;
    cyc(2);
    rst = 1'b0;
    chk("reads_in_rst", n_reads - base, 32'd0);
    push(4'b1001);
    wait_idle(300);
    cyc(3);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      cyc(1);
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 6) push(DATA_W'($urandom));
      tx_enable = ($urandom_range(0, 7) != 0);
    end
    tx_enable = 1'b1;
    wait_idle(3000);
    cyc(FRAME + 3);
    chk("reads_total", n_reads, n_starts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Drain-side transmitter for the 4-bit `fifo` buffer. It pops words from the FIFO using the FIFO's `mode` / `empty` interface, latches each word, and sends it LSB-first on a single serial line as a start / data / stop frame. It sits between the FIFO read port and an off-block serial link, and it is the only agent that drives the FIFO's read mode.

## Interface
Parameters:
- `DATA_W`, default 4: FIFO word width and number of data bits per frame.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dataout`  in  DATA_W  FIFO read data.
- `fifo_mode`  out  2  FIFO command: 2'b00 idle, 2'b10 read. Never drives 2'b01 or 2'b11.
- `tx_enable`  in  1  permits new frames to start.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the POP state through the STOP state.
- `done`  out  1  one-cycle pulse after each frame completes.

## Operation
- FIFO read contract:
  - The FIFO samples `fifo_mode` = 2'b10 at a clock edge.
  - The popped word is valid on `fifo_dataout` throughout the following cycle.
- All outputs are registered or Moore (decoded from the state register only).
- States and transitions:
  - IDLE: if `tx_enable` && !`fifo_empty`, go to POP; otherwise stay.
  - POP: `fifo_mode` = 2'b10 for exactly one cycle, then LATCH.
  - LATCH: capture `fifo_dataout` into the shift register, then START.
  - START: `tx` = 0 for one bit period.
  - DATA: shift out DATA_W bits, LSB first, one bit period each.
  - PARITY: present only when compiled in; see Configuration.
  - STOP: `tx` = 1 for one bit period, then IDLE.
- `done` is asserted in the first IDLE cycle after STOP.
- `fifo_empty` and `tx_enable` are sampled only in IDLE.
  - Deasserting either mid-frame does not abort the current frame.
  - No further POP occurs while the condition is false.
- The bit counter and baud counter width is `$clog2` of the respective maximum, minimum 1.

## Timing
- Reset values: `tx`=1, `fifo_mode`=2'b00, `busy`=0, `done`=0; state IDLE; counters 0.
- Start latency: if cycle n is the IDLE cycle where the start condition holds:
  - POP occurs in cycle n+1.
  - LATCH occurs in n+2.
  - The falling edge of `tx` occurs at the start of n+3.
- Frame length: 3 + (DATA_W+2)×CLKS_PER_BIT cycles from cycle n to the `done` cycle. With defaults this is 27.
- Back-to-back frames: the `done` cycle is itself an IDLE cycle and can qualify the next frame. Minimum inter-frame gap is 1 cycle of `tx`=1 beyond the stop bit, plus 3 cycles of pipeline.
- Each frame produces exactly one read strobe. A read is never issued while `fifo_empty` was high in the qualifying cycle.
- Reset mid-frame:
  - Next cycle: `tx`=1, `fifo_mode`=2'b00, state IDLE.
  - A word already popped is discarded.
  - No POP is issued while `rst` is high.

## Configuration
- Macro `FIFO_TX_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the data bits) for one bit period.
  - Frame length becomes 3 + (DATA_W+3)×CLKS_PER_BIT.
- Undefined: no PARITY state exists and the frame timing is as described under Timing.

## Structure
- Package `fifo_tx_pkg` contains:
  - The state encoding: IDLE, POP, LATCH, START, DATA, PARITY, STOP.
  - FIFO mode constants: `MODE_IDLE` = 2'b00, `MODE_WRITE` = 2'b01, `MODE_READ` = 2'b10.
- One sub-module, `fifo_tx_baud_counter`:
  - Counts 0..CLKS_PER_BIT-1.
  - Emits a one-cycle `bit_tick` on the last count.
  - Cleared by `rst` and on entry to START.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → `tx`=1, `fifo_mode`=00, `busy`=0, `done`=0 on every cycle.
- Single word: FIFO model holds 4'b1010, `tx_enable`=1 →
  - `fifo_mode`=10 for exactly one cycle.
  - `tx` carries 0 | 0,1,0,1 | 1, each bit for 4 cycles.
  - `done` arrives 27 cycles after the qualifying cycle.
- Empty FIFO: `fifo_empty`=1, `tx_enable`=1 for 50 cycles → `fifo_mode` stays 00, `tx` stays 1, `busy` stays 0.
- Burst: FIFO model is loaded with 1000, 1110, 0010, 1011 →
  - Four frames are sent in order.
  - Exactly four read strobes occur.
  - No read is issued after `fifo_empty` rises.
- Reset mid-frame: assert `rst` during data bit 2 →
  - `tx`=1 on the next cycle.
  - No read is issued during reset.
  - The next frame after release starts cleanly.
- Parity (`FIFO_TX_PARITY_EN` defined): 4'b0111 → parity bit 1; 4'b1111 → parity bit 0; frame length is 31 cycles.
